// File: rtl/keccak_result_checker.sv
// Pairs issued nonces with Keccak-800 hasher results in order, checks each hash
// against a 256-bit target and presents qualifying nonces through a one-entry slot.
module keccak_result_checker #(
    parameter int DEPTH   = 32,
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [NONCE_W-1:0] issue_nonce,
    input  logic               hash_valid,
    input  logic [255:0]       hash,
    input  logic [255:0]       target,
    output logic               match_valid,
    input  logic               match_ready,
    output logic [NONCE_W-1:0] match_nonce,
    output logic [31:0]        hash_count,
    output logic [7:0]         dropped,
    output logic               error
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // ------------------------------------------------------------------
    // Nonce FIFO
    // ------------------------------------------------------------------
    logic [NONCE_W-1:0] fifo_mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               do_push;
    logic               do_pop;
    logic               err_set;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = hash_valid && !fifo_empty;
    assign do_push = issue_valid && (!fifo_full || do_pop);
    assign err_set = (issue_valid && fifo_full && !do_pop) ||
                     (hash_valid && fifo_empty);

    // NOTE: storage has no reset; only the pointers define what is valid,
    // so clearing the array would cost a reset net for no behavioural gain.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= issue_nonce;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            error  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (err_set) error  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Compare pipeline
    // ------------------------------------------------------------------
    logic               s1_valid;
    logic [255:0]       s1_hash;
    logic [NONCE_W-1:0] s1_nonce;
    logic               s2_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= do_pop;
        end
    end

    always_ff @(posedge clk) begin
        s1_hash  <= hash;
        s1_nonce <= fifo_mem[rd_ptr[AW-1:0]];
    end

    assign s2_hit = s1_valid && (s1_hash <= target);

    always_ff @(posedge clk) begin
        if (reset) begin
            hash_count <= '0;
        end else if (s1_valid) begin
            hash_count <= hash_count + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result slot
    // ------------------------------------------------------------------
    logic [0:0] slot_state;
    logic [0:0] slot_next;
    logic       slot_load;
    logic       slot_drop;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        slot_next = slot_state;
        slot_load = 1'b0;
        slot_drop = 1'b0;
        case (slot_state)
            ST_EMPTY: begin
                if (s2_hit) begin
                    slot_next = ST_FULL;
                    slot_load = 1'b1;
                end
            end
            ST_FULL: begin
                if (s2_hit) begin
                    if (match_ready) slot_load = 1'b1;
                    else             slot_drop = 1'b1;
                end else if (match_ready) begin
                    slot_next = ST_EMPTY;
                end
            end
            default: slot_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_state  <= ST_EMPTY;
            match_nonce <= '0;
            dropped     <= '0;
        end else begin
            slot_state <= slot_next;
            if (slot_load) match_nonce <= s1_nonce;
            if (slot_drop && (dropped != 8'hFF)) dropped <= dropped + 8'd1;
        end
    end

    assign match_valid = (slot_state == ST_FULL);

endmodule

// File: doc/keccak_result_checker.md
# keccak_result_checker

Downstream companion to the Keccak-800 hasher pipeline. Tracks the nonce of every work item issued to the hasher in an in-order FIFO, pairs each nonce with the hash the hasher emits, and compares that hash against a 256-bit target. Qualifying nonces are presented to the host-reporting logic through a single-entry valid/ready result slot.

## Interface
Parameters:
- DEPTH, 32, nonce FIFO entries; power of two, ≥ hasher LATENCY/THROUGHPUT + 2
- NONCE_W, 32, nonce width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  high for one cycle when a work item enters the hasher; same cycle as the hasher's read
- issue_nonce  in  NONCE_W  nonce of that work item
- hash_valid  in  1  hasher write strobe
- hash  in  256  hasher out; bit 255 is the MSB for comparison
- target  in  256  unsigned threshold; held stable while hashing
- match_valid  out  1  result slot occupied
- match_ready  in  1  consumer accepts the slot
- match_nonce  out  NONCE_W  nonce whose hash ≤ target
- hash_count  out  32  hashes checked, wraps modulo 2^32
- dropped  out  8  matches lost to a full slot, saturates at 255
- error  out  1  sticky; FIFO overflow or underflow

## Operation
- Nonce FIFO: circular buffer of DEPTH entries with log2(DEPTH)+1-bit read/write pointers; full when the pointers differ only in the MSB.
  - Push on issue_valid.
  - Pop on hash_valid.
- Push while full and no simultaneous pop: entry discarded, error set. Push and pop in the same cycle while full: both succeed, occupancy unchanged.
- Pop while empty: error set, no pipeline entry created. A same-cycle push is still accepted, because a hash can never belong to a same-cycle issue.
- Compare pipeline:
  - Stage 1 registers hash, the popped nonce and a valid bit.
  - Stage 2 evaluates hash ≤ target (unsigned, all 256 bits) and increments hash_count for each valid stage-1 entry.
- Result slot, two states:
  - EMPTY → FULL on a stage-2 match; slot loads match_nonce.
  - FULL → EMPTY on match_ready with no new match.
  - FULL with match_ready and a new match in the same cycle: loads the new nonce, stays FULL, dropped unchanged.
  - FULL without match_ready and a new match: existing nonce kept, dropped increments (saturating).
- match_nonce holds its value while match_valid is high. It is don't-care while low but must not change while high.
- Reset clears pointers, the pipeline valid bit, the slot state, hash_count, dropped and error. FIFO storage is not cleared.
- Reset mid-operation: hashes still in flight inside the hasher arrive after reset with an empty FIFO and set error. The hasher's in-flight work must be drained by the controller before reset is released; this block does not mask them.

## Timing
- Reset values: match_valid=0, match_nonce=0, hash_count=0, dropped=0, error=0.
- hash_valid sampled at edge E:
  - stage 1 loaded at E;
  - match_valid and match_nonce updated at E+1;
  - hash_count updated at E+1.
- Issue-to-pop: the FIFO entry is visible to a pop from the edge after the push.
- One hash per cycle sustained; no backpressure to the hasher.
- error rises at the edge where the offending push or pop is sampled.
- match_ready is only meaningful while match_valid=1. The slot frees at the sampling edge, so a new result may appear one cycle later at the earliest.

## Test plan
- Single hit: target=2^255, issue nonce 0x00000005, hash MSB=0, hash_valid 26 cycles later → match_valid=1, match_nonce=0x5 exactly 2 edges after hash_valid; hash_count=1.
- Miss ordering: issue nonces 1, 2, 3; hashes {all-ones, 0x0…01, all-ones}, target=0x10 → only nonce 2 reported; hash_count=3; dropped=0.
- Backpressure: match_ready=0, five consecutive hits with nonces 10–14 → match_nonce=10 held, dropped=4. Then assert match_ready for one cycle while hit nonce 15 arrives → match_nonce=15, dropped=4.
- Saturation: 300 hits with match_ready=0 → dropped=255.
- FIFO full: DEPTH=4, 5 issues with no hashes → error=1, first 4 nonces still paired correctly with subsequent hashes. Separately, push+pop on a full FIFO → error stays 0.
- Underflow and reset: hash_valid with an empty FIFO → error=1, hash_count unchanged. Assert reset for 1 cycle → all outputs 0; next issue/hash pair is reported correctly.
